pcont_perfcnt: RTL
==================

Name: pcont_perfcnt

Overview:
- Parametrised performance-event counter bank; successor to the fixed single-pulse CNT*_R event outputs of the pipeline control block.
- NUM_CNT counters, each CNT_W wide. Each counter is programmable via a CSR port to count any one of NUM_EVT event lines.
- Per-counter hold masking, sticky overflow with interrupt, global enable, global clear and atomic snapshot.
- Sits beside pipeline control; its EVT_R inputs are driven by the registered event pulses.

Parameters:
- NUM_CNT, 4, number of counters (1..16).
- CNT_W, 32, counter width (8..32).
- NUM_EVT, 8, number of event input lines (2..256).
- SEL_W, clog2(NUM_EVT), event-select field width (derived; not overridden).
- ADDR_W, clog2(3*NUM_CNT+1), CSR word address width (derived).

Ports:
- SYSCLK  in  1  system clock; all logic on posedge.
- RESET_D1_R  in  1  synchronous, active-high reset.
- EVT_R  in  NUM_EVT  registered single-cycle event pulses; bit i counts once per cycle high.
- RHOLD  in  1  pipeline hold; suppresses counting on counters with HOLD_MASK set.
- CSR_WE  in  1  write strobe.
- CSR_RE  in  1  read strobe.
- CSR_ADDR  in  ADDR_W  word address.
- CSR_WDATA  in  32  write data.
- CSR_RDATA  out  32  read data, valid when CSR_RVAL is high.
- CSR_RVAL  out  1  read-data valid, one cycle after CSR_RE.
- PERF_IRQ  out  1  registered OR over counters of (OVF & IRQ_EN).

Behaviour:
- Reset: all counters, shadows and CTRL fields are 0, GEN=0, CSR_RDATA=0, CSR_RVAL=0, PERF_IRQ=0. Reset overrides any same-cycle CSR write or event.
- Address map, for counter i: CTRL at 3i, COUNT at 3i+1, SHADOW at 3i+2 (read-only). GLOBAL is at 3*NUM_CNT. All other addresses read as 0; writes to them are ignored.
- CTRL bits:
  - [0] EN.
  - [1] HOLD_MASK.
  - [2] IRQ_EN.
  - [3] OVF: sticky; writing 1 clears it, writing 0 has no effect.
  - [8+:SEL_W] EVT_SEL.
  - All other bits read 0.
- GLOBAL bits:
  - [0] GEN, read/write.
  - [1] SNAP: write-1 pulse, reads 0.
  - [2] CLR_ALL: write-1 pulse, reads 0.
  - [31:16] read-only NUM_CNT.
- Increment condition for counter i in cycle t: GEN & EN & EVT_R[EVT_SEL] & ~(HOLD_MASK & RHOLD). The counter value updates at the end of cycle t (one-cycle latency).
  - If EVT_SEL >= NUM_EVT, the counter never increments.
- Wrap: counter at all-ones plus an increment goes to 0 and sets OVF. No saturation.
- COUNT write versus same-cycle increment: the write wins, and OVF is not set by that increment. Written data is truncated to CNT_W bits.
- OVF set (wrap) and OVF W1C in the same cycle: set wins.
- CLR_ALL: zeroes every counter and every OVF in the next cycle. It takes priority over increments and COUNT writes in that cycle. CTRL fields other than OVF are untouched.
- SNAP: copies every counter into its SHADOW in one cycle, capturing values before any same-cycle increment, write or clear. SNAP and CLR_ALL together: the shadow holds the pre-clear values.
- Read path:
  - CSR_RE in cycle t gives CSR_RVAL=1 and CSR_RDATA in cycle t+1.
  - Data is the register value at the start of cycle t, so it does not include a same-cycle write or increment.
  - CSR_RDATA holds its last value while CSR_RVAL=0.
  - Counter reads are zero-extended to 32 bits.
- Read and write in the same cycle (same or different address): both are performed; the read returns the pre-write value.
- PERF_IRQ is registered: it rises the cycle after OVF&IRQ_EN becomes true and falls the cycle after that OVF is cleared.

Decomposition:
- Package pcont_perfcnt_pkg holds:
  - CTRL/GLOBAL bit-position constants.
  - Address offsets (CTRL=0, COUNT=1, SHADOW=2 per stride of 3).
  - A ctrl-field struct/typedef.
- Sub-module pcont_perfcnt_slice: one counter with its CTRL, OVF and SHADOW. The top instantiates NUM_CNT slices via generate and adds the decode, GLOBAL register, read mux and IRQ reduction.

Test Plan:
- Reset then count: set GEN=1, CTRL0 EN=1, EVT_SEL=2, pulse EVT_R[2] 5 cycles -> COUNT0 reads 5; other counters read 0.
- Hold mask: CTRL1 EN=1, HOLD_MASK=1, EVT_SEL=0, EVT_R[0] high 10 cycles with RHOLD high for 4 of them -> COUNT1=6. Same with HOLD_MASK=0 -> 10.
- Wrap/IRQ: CNT_W=8, write COUNT0=0xFE, IRQ_EN=1, 2 events -> COUNT0=0x00, OVF=1, PERF_IRQ=1 next cycle. W1C OVF -> PERF_IRQ=0 a cycle later.
- Write vs increment: write COUNT2=0x100 in the same cycle EVT fires -> COUNT2 reads 0x100, not 0x101.
- Snapshot+clear: counters at 7,3,0,9, write GLOBAL=0x7 -> SHADOW reads 7,3,0,9, COUNT reads 0 for all, GEN stays 1, GLOBAL read returns 0x0004_0001.
- Sync reset mid-count: assert RESET_D1_R during events and a CSR write -> next cycle all counters, CTRL, CSR_RVAL and PERF_IRQ are 0; a read of an unmapped address returns 0 with CSR_RVAL=1.

Source files
------------

// File: rtl/pcont_perfcnt_pkg.sv
// Purpose: shared constants and the CTRL field record for the perf-counter bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcont_perfcnt_pkg;

    // CTRL register bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_HOLD_BIT = 1;
    localparam int CTRL_IRQ_BIT  = 2;
    localparam int CTRL_OVF_BIT  = 3;
    localparam int CTRL_SEL_LSB  = 8;

    // GLOBAL register bit positions
    localparam int GLB_GEN_BIT  = 0;
    localparam int GLB_SNAP_BIT = 1;
    localparam int GLB_CLR_BIT  = 2;
    localparam int GLB_NCNT_LSB = 16;

    // Per-counter register offsets inside one stride
    localparam int OFS_CTRL   = 0;
    localparam int OFS_COUNT  = 1;
    localparam int OFS_SHADOW = 2;
    localparam int REG_STRIDE = 3;

    // Event select storage is sized for the largest legal NUM_EVT (256);
    // each slice masks it down to its real SEL_W on write.
    localparam int MAX_SEL_W = 8;

    typedef struct packed {
        logic [MAX_SEL_W-1:0] evt_sel;
        logic                 ovf;
        logic                 irq_en;
        logic                 hold_mask;
        logic                 en;
    } ctrl_t;

    // CTRL read-back word; unused bits read as zero.
    function automatic logic [31:0] ctrl_word(ctrl_t c);
        return {16'h0000, c.evt_sel, 4'h0, c.ovf, c.irq_en, c.hold_mask, c.en};
    endfunction

endpackage

// File: rtl/pcont_perfcnt_if.sv
// Purpose: CSR word-access bus between a host and the perf-counter bank.
// Latency: read data returned one cycle after CSR_RE; writes take effect at the strobe edge.
// Backpressure: none; the slave accepts every strobe.
interface pcont_perfcnt_if #(
    parameter int ADDR_W = 4
) ();
    logic              CSR_WE;
    logic              CSR_RE;
    logic [ADDR_W-1:0] CSR_ADDR;
    logic [31:0]       CSR_WDATA;
    logic [31:0]       CSR_RDATA;
    logic              CSR_RVAL;

    modport master (
        output CSR_WE, CSR_RE, CSR_ADDR, CSR_WDATA,
        input  CSR_RDATA, CSR_RVAL
    );

    modport slave (
        input  CSR_WE, CSR_RE, CSR_ADDR, CSR_WDATA,
        output CSR_RDATA, CSR_RVAL
    );
endinterface

// File: rtl/pcont_perfcnt_slice.sv
// Purpose: one performance counter with its CTRL fields, sticky OVF and SHADOW.
// Latency: increment, write, clear and snapshot all land at the end of the cycle they occur in.
// Backpressure: none.
// Ports: SYSCLK/RESET_D1_R clock and sync reset; gen/evt/rhold count qualifiers;
//        ctrl_we/cnt_we/snap/clr_all/wdata from the top decode; *_rd read-back words; irq_src = OVF & IRQ_EN.
module pcont_perfcnt_slice
    import pcont_perfcnt_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int NUM_EVT = 8,
    parameter int SEL_W   = 3
) (
    input  logic               SYSCLK,
    input  logic               RESET_D1_R,
    input  logic               gen,
    input  logic               rhold,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               ctrl_we,
    input  logic               cnt_we,
    input  logic               snap,
    input  logic               clr_all,
    input  logic [31:0]        wdata,
    output logic [31:0]        ctrl_rd,
    output logic [31:0]        cnt_rd,
    output logic [31:0]        shadow_rd,
    output logic               irq_src
);

    localparam logic [MAX_SEL_W-1:0] SEL_MASK = MAX_SEL_W'((1 << SEL_W) - 1);

    ctrl_t            ctrl;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;
    logic             evt_hit;
    logic             inc;
    logic             wrap;
    logic             unused_wdata;

    assign unused_wdata = ^wdata;

    // Select by compare rather than by index so a select value at or above
    // NUM_EVT simply matches no line and the counter never moves.
    always_comb begin
        evt_hit = 1'b0;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (ctrl.evt_sel == MAX_SEL_W'(k)) begin
                evt_hit = evt[k];
            end
        end
    end

    assign inc  = gen & ctrl.en & evt_hit & ~(ctrl.hold_mask & rhold);
    assign wrap = inc & (&cnt);

    always_ff @(posedge SYSCLK) begin
        if (RESET_D1_R) begin
            ctrl   <= '0;
            cnt    <= '0;
            shadow <= '0;
        end else begin
            if (ctrl_we) begin
                ctrl.en        <= wdata[CTRL_EN_BIT];
                ctrl.hold_mask <= wdata[CTRL_HOLD_BIT];
                ctrl.irq_en    <= wdata[CTRL_IRQ_BIT];
                ctrl.evt_sel   <= wdata[CTRL_SEL_LSB +: MAX_SEL_W] & SEL_MASK;
            end

            // Clear beats everything; a wrap that a COUNT write overrides never
            // happened; a real wrap beats a same-cycle W1C.
            if (clr_all) begin
                ctrl.ovf <= 1'b0;
            end else if (wrap && !cnt_we) begin
                ctrl.ovf <= 1'b1;
            end else if (ctrl_we && wdata[CTRL_OVF_BIT]) begin
                ctrl.ovf <= 1'b0;
            end

            if (clr_all) begin
                cnt <= '0;
            end else if (cnt_we) begin
                cnt <= wdata[CNT_W-1:0];
            end else if (inc) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Captures the pre-edge value, so same-cycle clear/write/increment is excluded.
            if (snap) begin
                shadow <= cnt;
            end
        end
    end

    assign ctrl_rd   = ctrl_word(ctrl);
    assign cnt_rd    = 32'(cnt);
    assign shadow_rd = 32'(shadow);
    assign irq_src   = ctrl.ovf & ctrl.irq_en;

endmodule

// File: rtl/pcont_perfcnt.sv
// Purpose: bank of NUM_CNT programmable event counters with CSR access, snapshot, clear and IRQ.
// Latency: CSR read data one cycle after CSR_RE; PERF_IRQ one cycle after OVF&IRQ_EN changes.
// Backpressure: none; every CSR strobe is accepted in the cycle it is presented.
// Ports: SYSCLK clock; RESET_D1_R sync active-high reset; EVT_R event pulses; RHOLD pipeline hold;
//        csr CSR slave bus; PERF_IRQ registered OR of per-counter OVF&IRQ_EN.
module pcont_perfcnt
    import pcont_perfcnt_pkg::*;
#(
    parameter  int NUM_CNT = 4,
    parameter  int CNT_W   = 32,
    parameter  int NUM_EVT = 8,
    localparam int SEL_W   = $clog2(NUM_EVT),
    localparam int ADDR_W  = $clog2(3 * NUM_CNT + 1)
) (
    input  logic               SYSCLK,
    input  logic               RESET_D1_R,
    input  logic [NUM_EVT-1:0] EVT_R,
    input  logic               RHOLD,
    pcont_perfcnt_if.slave     csr,
    output logic               PERF_IRQ
);

    localparam logic [ADDR_W-1:0] GLB_ADDR = ADDR_W'(REG_STRIDE * NUM_CNT);

    logic               gen;
    logic               glb_we;
    logic               snap;
    logic               clr_all;
    logic [NUM_CNT-1:0] ctrl_we;
    logic [NUM_CNT-1:0] cnt_we;
    logic [NUM_CNT-1:0] irq_src;
    logic [31:0]        ctrl_rd   [NUM_CNT];
    logic [31:0]        cnt_rd    [NUM_CNT];
    logic [31:0]        shadow_rd [NUM_CNT];
    logic [31:0]        rd_mux;

    assign glb_we  = csr.CSR_WE && (csr.CSR_ADDR == GLB_ADDR);
    assign snap    = glb_we && csr.CSR_WDATA[GLB_SNAP_BIT];
    assign clr_all = glb_we && csr.CSR_WDATA[GLB_CLR_BIT];

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        assign ctrl_we[g] = csr.CSR_WE && (csr.CSR_ADDR == ADDR_W'(REG_STRIDE * g + OFS_CTRL));
        assign cnt_we[g]  = csr.CSR_WE && (csr.CSR_ADDR == ADDR_W'(REG_STRIDE * g + OFS_COUNT));

        pcont_perfcnt_slice #(
            .CNT_W   (CNT_W),
            .NUM_EVT (NUM_EVT),
            .SEL_W   (SEL_W)
        ) u_slice (
            .SYSCLK     (SYSCLK),
            .RESET_D1_R (RESET_D1_R),
            .gen        (gen),
            .rhold      (RHOLD),
            .evt        (EVT_R),
            .ctrl_we    (ctrl_we[g]),
            .cnt_we     (cnt_we[g]),
            .snap       (snap),
            .clr_all    (clr_all),
            .wdata      (csr.CSR_WDATA),
            .ctrl_rd    (ctrl_rd[g]),
            .cnt_rd     (cnt_rd[g]),
            .shadow_rd  (shadow_rd[g]),
            .irq_src    (irq_src[g])
        );
    end

    // Unmatched addresses fall through to zero.
    always_comb begin
        rd_mux = 32'h0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (csr.CSR_ADDR == ADDR_W'(REG_STRIDE * i + OFS_CTRL))   rd_mux = ctrl_rd[i];
            if (csr.CSR_ADDR == ADDR_W'(REG_STRIDE * i + OFS_COUNT))  rd_mux = cnt_rd[i];
            if (csr.CSR_ADDR == ADDR_W'(REG_STRIDE * i + OFS_SHADOW)) rd_mux = shadow_rd[i];
        end
        if (csr.CSR_ADDR == GLB_ADDR) begin
            rd_mux[GLB_GEN_BIT]         = gen;
            rd_mux[GLB_NCNT_LSB +: 16]  = 16'(NUM_CNT);
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET_D1_R) begin
            gen           <= 1'b0;
            csr.CSR_RDATA <= 32'h0;
            csr.CSR_RVAL  <= 1'b0;
            PERF_IRQ      <= 1'b0;
        end else begin
            if (glb_we) begin
                gen <= csr.CSR_WDATA[GLB_GEN_BIT];
            end
            csr.CSR_RVAL <= csr.CSR_RE;
            // Sampled from pre-edge state, so a same-cycle write is not visible.
            if (csr.CSR_RE) begin
                csr.CSR_RDATA <= rd_mux;
            end
            PERF_IRQ <= |irq_src;
        end
    end

endmodule
